// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the write-back queue and its forwarding logic.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-match select over the queue entries for one read port.
// Entries are walked oldest to youngest from the head, so the last hit wins.
module wbq_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0]      entries_i,
    input  logic [PTR_W-1:0]           head_i,
    input  logic [REG_ADDR_W-1:0]      addr_i,
    output logic                       hit_o,
    output logic [REG_DATA_W-1:0]      data_o
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (entries_i[idx].valid && (entries_i[idx].addr == addr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of a register-file write port, with read-port
// forwarding of pending writes.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [REG_ADDR_W-1:0] InRegister,
    input  logic [REG_DATA_W-1:0] InData,
    input  logic                  DrainEnable,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [REG_DATA_W-1:0] WriteData,
    input  logic [REG_ADDR_W-1:0] ReadRegister1,
    input  logic [REG_ADDR_W-1:0] ReadRegister2,
    input  logic [REG_DATA_W-1:0] RegData1,
    input  logic [REG_DATA_W-1:0] RegData2,
    output logic [REG_DATA_W-1:0] ReadData1,
    output logic [REG_DATA_W-1:0] ReadData2,
    output logic [3:0]            Count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [3:0]            count_q, count_d;

    logic      push;
    logic      pop;
    wb_entry_t head;

    logic                  hit1, hit2;
    logic [REG_DATA_W-1:0] fwd1, fwd2;

    assign head = entries_q[rd_ptr_q];

    // count_q is cleared asynchronously, so these need no explicit reset gating
    // beyond InReady, which must drop while reset is held.
    assign InReady       = Rst_n && (count_q < 4'(DEPTH));
    assign RegWrite      = DrainEnable && (count_q != 4'd0);
    assign WriteRegister = (count_q != 4'd0) ? head.addr : '0;
    assign WriteData     = (count_q != 4'd0) ? head.data : '0;
    assign Count         = count_q;

    assign push = InValid && InReady && (InRegister != ZERO_REG);
    assign pop  = RegWrite;

    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;

        if (pop) begin
            entries_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d                  = rd_ptr_q + 1'b1;
        end
        if (push) begin
            entries_d[wr_ptr_q].valid = 1'b1;
            entries_d[wr_ptr_q].addr  = InRegister;
            entries_d[wr_ptr_q].data  = InData;
            wr_ptr_d                  = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            entries_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    wbq_match #(.DEPTH(DEPTH)) u_match1 (
        .entries_i (entries_q),
        .head_i    (rd_ptr_q),
        .addr_i    (ReadRegister1),
        .hit_o     (hit1),
        .data_o    (fwd1)
    );

    wbq_match #(.DEPTH(DEPTH)) u_match2 (
        .entries_i (entries_q),
        .head_i    (rd_ptr_q),
        .addr_i    (ReadRegister2),
        .hit_o     (hit2),
        .data_o    (fwd2)
    );

    always_comb begin
        ReadData1 = RegData1;
        ReadData2 = RegData2;
        if (ReadRegister1 == ZERO_REG) ReadData1 = '0;
        else if (hit1)                 ReadData1 = fwd1;
        if (ReadRegister2 == ZERO_REG) ReadData2 = '0;
        else if (hit2)                 ReadData2 = fwd2;
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: a queue model tracks pending writes,
// the write port is checked every cycle and forwarding is checked against the model.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    logic        Clk;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRegister;
    logic [31:0] InData;
    logic        DrainEnable;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] RegData1;
    logic [31:0] RegData2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [3:0]  Count;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .InValid       (InValid),
        .InReady       (InReady),
        .InRegister    (InRegister),
        .InData        (InData),
        .DrainEnable   (DrainEnable),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .RegData1      (RegData1),
        .RegData2      (RegData2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .Count         (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_model(input logic [4:0] a, input logic [31:0] raw);
        logic [31:0] r;
        r = raw;
        if (a == 5'd0) return 32'd0;
        foreach (sb[i]) if (sb[i].a == a) r = sb[i].d;
        return r;
    endfunction

    // Model update on the edge, from bench-side values only.
    always @(posedge Clk) begin
        if (!Rst_n) sb.delete();
        else begin
            int  sz;
            sz = sb.size();
            if (DrainEnable && sz != 0) void'(sb.pop_front());
            if (InValid && sz < DEPTH && InRegister != 5'd0) sb.push_back('{a: InRegister, d: InData});
        end
    end

    always @(negedge Rst_n) sb.delete();

    // Write-port and occupancy checks mid-cycle.
    always @(negedge Clk) begin
        if (Rst_n) begin
            chk("count", 32'(Count), 32'(sb.size()));
            chk("in_ready", 32'(InReady), 32'(sb.size() < DEPTH));
            chk("reg_write", 32'(RegWrite), 32'(DrainEnable && sb.size() != 0));
            if (sb.size() != 0) begin
                chk("wr_reg", 32'(WriteRegister), 32'(sb[0].a));
                chk("wr_data", WriteData, sb[0].d);
            end else begin
                chk("wr_reg_idle", 32'(WriteRegister), 32'd0);
                chk("wr_data_idle", WriteData, 32'd0);
            end
            chk("rd1_fwd", ReadData1, fwd_model(ReadRegister1, RegData1));
            chk("rd2_fwd", ReadData2, fwd_model(ReadRegister2, RegData2));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        Rst_n         = 1'b0;
        InValid       = 1'b0;
        InRegister    = 5'd0;
        InData        = 32'd0;
        DrainEnable   = 1'b1;
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd0;
        RegData1      = 32'h1234;
        RegData2      = 32'h5;
        #2;
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_in_ready", 32'(InReady), 32'd0);
        chk("rst_reg_write", 32'(RegWrite), 32'd0);
        chk("rst_wr_reg", 32'(WriteRegister), 32'd0);
        chk("rst_wr_data", WriteData, 32'd0);
        chk("rst_rd1_pass", ReadData1, 32'h1234);
        chk("rst_rd2_zero", ReadData2, 32'd0);

        // Basic write: first edge after release accepts, next cycle drives the port.
        InValid    = 1'b1;
        InRegister = 5'd5;
        InData     = 32'hDEADBEEF;
        #20;
        Rst_n = 1'b1;
        tick();
        InValid = 1'b0;
        #1;
        chk("basic_reg_write", 32'(RegWrite), 32'd1);
        chk("basic_wr_reg", 32'(WriteRegister), 32'd5);
        chk("basic_wr_data", WriteData, 32'hDEADBEEF);
        tick();
        chk("basic_count_zero", 32'(Count), 32'd0);

        // Full and back-pressure.
        DrainEnable = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            InValid    = 1'b1;
            InRegister = 5'(i);
            InData     = 32'(i * 'h11);
            tick();
        end
        InRegister = 5'd9;
        InData     = 32'h99;
        #1;
        chk("full_in_ready", 32'(InReady), 32'd0);
        chk("full_count", 32'(Count), 32'd4);
        tick();
        tick();
        chk("full_no_5th", 32'(Count), 32'd4);
        InValid     = 1'b0;
        DrainEnable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_order_reg", 32'(WriteRegister), 32'(i));
            chk("drain_order_data", WriteData, 32'(i * 'h11));
            tick();
        end
        chk("drain_empty", 32'(Count), 32'd0);

        // Forwarding: youngest match wins, head being drained still forwards.
        DrainEnable   = 1'b0;
        ReadRegister1 = 5'd7;
        RegData1      = 32'hAAAA;
        InValid = 1'b1; InRegister = 5'd7; InData = 32'h1; tick();
        InData = 32'h2; tick();
        InValid = 1'b0;
        #1;
        chk("fwd_youngest", ReadData1, 32'h2);
        DrainEnable = 1'b1;
        tick();
        chk("fwd_head_drain", ReadData1, 32'h2);
        tick();
        chk("fwd_after_drain", ReadData1, 32'hAAAA);
        DrainEnable = 1'b0;
        InValid = 1'b1; InRegister = 5'd7; InData = 32'h77;
        #1;
        chk("fwd_not_accepted", ReadData1, 32'hAAAA);
        tick();
        InRegister = 5'd3; InData = 32'h33; tick();
        InRegister = 5'd4; InData = 32'h44; tick();
        InValid       = 1'b0;
        ReadRegister2 = 5'd3;
        RegData2      = 32'h5;
        #1;
        chk("fwd_accepted", ReadData1, 32'h77);
        chk("fwd_older_match", ReadData2, 32'h33);
        DrainEnable = 1'b1;
        tick(); tick(); tick();
        chk("fwd_done_count", 32'(Count), 32'd0);

        // Zero register discarded.
        InValid = 1'b1; InRegister = 5'd0; InData = 32'hFFFFFFFF;
        ReadRegister2 = 5'd0;
        RegData2      = 32'h5;
        tick();
        InValid = 1'b0;
        #1;
        chk("zero_count", 32'(Count), 32'd0);
        chk("zero_reg_write", 32'(RegWrite), 32'd0);
        chk("zero_rd2", ReadData2, 32'd0);
        tick();

        // Simultaneous push/pop at Count = 2 across pointer wrap.
        DrainEnable = 1'b0;
        InValid = 1'b1; InRegister = 5'd10; InData = 32'h100; tick();
        InRegister = 5'd11; InData = 32'h101; tick();
        DrainEnable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            InRegister = 5'(12 + k);
            InData     = 32'(32'h200 + k);
            tick();
            chk("pushpop_count", 32'(Count), 32'd2);
        end
        InValid = 1'b0;
        tick(); tick(); tick();
        chk("pushpop_drained", 32'(Count), 32'd0);

        // Asynchronous reset with pending writes.
        DrainEnable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            InValid = 1'b1; InRegister = 5'(20 + i); InData = 32'(32'h300 + i);
            tick();
        end
        InValid = 1'b0;
        #1;
        chk("pre_rst_count", 32'(Count), 32'd3);
        @(negedge Clk);
        #2;
        Rst_n       = 1'b0;
        DrainEnable = 1'b1;
        #1;
        chk("async_rst_count", 32'(Count), 32'd0);
        chk("async_rst_reg_write", 32'(RegWrite), 32'd0);
        chk("async_rst_in_ready", 32'(InReady), 32'd0);
        tick();
        Rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_count", 32'(Count), 32'd0);
        chk("post_rst_reg_write", 32'(RegWrite), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of queue entries (power of two, 2..8).
REQ-003 Clk  input  1  clock; all state updates on the rising edge.
REQ-004 Rst_n  input  1  asynchronous active-low reset.
REQ-005 InValid  input  1  a write request is presented.
REQ-006 InReady  output  1  the queue can accept a request this cycle.
REQ-007 InRegister  input  5  destination register address of the request.
REQ-008 InData  input  32  data of the request.
REQ-009 DrainEnable  input  1  the register-file write port is available this cycle.
REQ-010 RegWrite  output  1  write enable to the register-file write port.
REQ-011 WriteRegister  output  5  address to the register-file write port.
REQ-012 WriteData  output  32  data to the register-file write port.
REQ-013 ReadRegister1 and ReadRegister2  input  5 each  read addresses also presented to the register file.
REQ-014 RegData1 and RegData2  input  32 each  raw register-file read data.
REQ-015 ReadData1 and ReadData2  output  32 each  read data with pending queued writes forwarded.
REQ-016 Count  output  4  number of occupied entries.

Function
REQ-017 InReady SHALL be 1 exactly when Count < DEPTH and Rst_n is high; it SHALL NOT depend on a same-cycle drain.
REQ-018 A request is accepted on a rising edge where InValid and InReady are both 1.
REQ-019 An accepted request with InRegister = 0 SHALL be discarded: no enqueue and no Count change.
REQ-020 An accepted request with a nonzero address SHALL be appended at the tail, in FIFO order.
REQ-021 RegWrite SHALL equal DrainEnable AND (Count != 0), combinationally.
REQ-022 WriteRegister and WriteData SHALL be driven from the head entry; when Count = 0, they SHALL be 0.
REQ-023 On an edge where RegWrite = 1, the head entry SHALL be popped.
REQ-024 Minimum latency SHALL be one cycle: a request accepted at edge N is driven on the write port during cycle N+1.
REQ-025 If a push and a pop occur on the same edge, Count SHALL be unchanged; with Count = 0, a same-edge push and pop is impossible.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 With DrainEnable = 0, the queue SHALL hold its contents indefinitely.
REQ-028 ReadDataX SHALL be 0 when ReadRegisterX = 0.
REQ-029 Otherwise, ReadDataX SHALL be the data of the youngest occupied entry whose register equals ReadRegisterX.
REQ-030 If no occupied entry matches, ReadDataX SHALL be RegDataX.
REQ-031 Forwarding SHALL include the head entry being drained in the current cycle.
REQ-032 The not-yet-accepted InData SHALL never be forwarded.
REQ-033 All outputs except ReadData1 and ReadData2 SHALL be glitch-free functions of registered state, Rst_n and DrainEnable.

Reset
REQ-034 While Rst_n is low:
- Count, pointers and all entry-valid bits SHALL be 0.
- InReady, RegWrite, WriteRegister and WriteData SHALL be 0.
- ReadDataX SHALL pass RegDataX through, except for address 0.
REQ-035 Asserting Rst_n mid-operation SHALL discard all pending writes immediately, with no partial write issued.
REQ-036 The first acceptance SHALL be possible on the first rising edge after Rst_n deasserts.

Structure
REQ-037 A shared package regfile_pkg SHALL hold the following:
- REG_ADDR_W = 5, REG_DATA_W = 32 and ZERO_REG = 0;
- typedef wb_entry_t {valid, addr[4:0], data[31:0]}.
REQ-038 One sub-module, wbq_match, SHALL implement the youngest-match priority select over the entries, given the head pointer.
REQ-039 wbq_match SHALL be instantiated once per read port.

Verification
REQ-040 Basic write: push r5 = 0xDEADBEEF at edge 1 with DrainEnable = 1.
- RegWrite = 1, WriteRegister = 5 and WriteData = 0xDEADBEEF during cycle 2.
- Count returns to 0 after edge 2.
REQ-041 Full and back-pressure: DrainEnable = 0, then push r1..r4 with data 0x11..0x44.
- InReady = 0 and Count = 4.
- A 5th InValid is not accepted.
- Raising DrainEnable drains r1, r2, r3, r4 on four consecutive cycles.
REQ-042 Forwarding: queue holds r7 = 0x1 then r7 = 0x2, DrainEnable = 0, ReadRegister1 = 7, RegData1 = 0xAAAA.
- ReadData1 = 0x2.
- After both entries drain, ReadData1 = 0xAAAA.
REQ-043 Zero register: push r0 = 0xFFFFFFFF.
- Count stays 0 and RegWrite is never asserted.
- With ReadRegister2 = 0 and RegData2 = 0x5, ReadData2 = 0.
REQ-044 Simultaneous push and pop at Count = 2 keeps Count = 2, with correct FIFO order across pointer wrap over 10 cycles.
REQ-045 Reset with Count = 3 clears Count to 0 and RegWrite to 0 without waiting for a clock; no stale write appears after release.
